// File: rtl/cpu_busarb.sv
// -----------------------------------------------------------------------------
// cpu_busarb -- two-master Wishbone arbiter for a CPU core.
//
// Master A is the data port and master B is the instruction-fetch port. Both
// share one slave bus. Ownership is held in a registered state (IDLE, OWN_A,
// OWN_B). A grant takes effect one cycle after the request. An owner keeps
// the bus until it drops cyc, and the other master never preempts it. A
// watchdog aborts a cycle that sees no ack or err for TIMEOUT cycles. The
// abort errors the owner and returns the arbiter to IDLE.
//
// Parameters
//   AW       address width in words
//   TIMEOUT  cycles without ack/err before an abort (2..1023)
//   OPT_RR   0: A always wins contention; 1: alternate on contention
//
// Ports
//   i_clk, i_rst               clock; synchronous active-high reset
//   i_a_* / o_a_*              master A request in, ack/stall/err out
//   i_b_* / o_b_*              master B request in, ack/stall/err out
//   o_wb_* / i_wb_*            slave request out, ack/stall/err in
//                              (read data goes from slave to masters directly)
//   o_owner                    00 idle, 01 A, 10 B
//   o_timeout                  one-cycle pulse on the cycle of an abort
// -----------------------------------------------------------------------------
module cpu_busarb #(
   parameter int AW      = 32,
   parameter int TIMEOUT = 1023,
   parameter int OPT_RR  = 0
) (
   input  logic          i_clk,
   input  logic          i_rst,
   // master A (data)
   input  logic          i_a_cyc,
   input  logic          i_a_stb,
   input  logic          i_a_we,
   input  logic [AW-1:0] i_a_addr,
   input  logic [31:0]   i_a_data,
   input  logic [3:0]    i_a_sel,
   output logic          o_a_ack,
   output logic          o_a_stall,
   output logic          o_a_err,
   // master B (instruction fetch)
   input  logic          i_b_cyc,
   input  logic          i_b_stb,
   input  logic          i_b_we,
   input  logic [AW-1:0] i_b_addr,
   input  logic [31:0]   i_b_data,
   input  logic [3:0]    i_b_sel,
   output logic          o_b_ack,
   output logic          o_b_stall,
   output logic          o_b_err,
   // slave
   output logic          o_wb_cyc,
   output logic          o_wb_stb,
   output logic          o_wb_we,
   output logic [AW-1:0] o_wb_addr,
   output logic [31:0]   o_wb_data,
   output logic [3:0]    o_wb_sel,
   input  logic          i_wb_ack,
   input  logic          i_wb_stall,
   input  logic          i_wb_err,
   // status
   output logic [1:0]    o_owner,
   output logic          o_timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      OWN_A = 2'b01,
      OWN_B = 2'b10
   } state_t;

   localparam logic [9:0] TIMEOUT_L = 10'(TIMEOUT);
   localparam logic [9:0] COUNT_MAX = 10'h3FF;

   state_t     state, state_next;
   logic [9:0] count, count_next;
   logic       last_b, last_b_next;   // 1: B held the most recent grant
   logic       owner_cyc;
   logic       abort;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values. Reset is sampled on the clock edge, so it takes effect on
   // the edge after i_rst rises.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= IDLE;
         count  <= '0;
         last_b <= 1'b1;
      end else begin
         state  <= state_next;
         count  <= count_next;
         last_b <= last_b_next;
      end
   end

   // The watchdog fires only while the owner still holds cyc. A slave ack or
   // err in the same cycle takes precedence over the abort.
   always_comb begin
      owner_cyc = 1'b0;
      case (state)
         OWN_A:   owner_cyc = i_a_cyc;
         OWN_B:   owner_cyc = i_b_cyc;
         default: owner_cyc = 1'b0;
      endcase
      abort = owner_cyc && (count == TIMEOUT_L) && !i_wb_ack && !i_wb_err;
   end

   // Next-state logic. Arbitration happens only from IDLE.
   // NOTE: every output of this block gets a default first. That stops
   // latches forming on paths that do not assign the signal.
   always_comb begin
      state_next  = state;
      last_b_next = last_b;
      case (state)
         IDLE: begin
            if (i_a_cyc && i_b_cyc) begin
               if ((OPT_RR != 0) && !last_b) begin
                  state_next  = OWN_B;
                  last_b_next = 1'b1;
               end else begin
                  state_next  = OWN_A;
                  last_b_next = 1'b0;
               end
            end else if (i_a_cyc) begin
               state_next  = OWN_A;
               last_b_next = 1'b0;
            end else if (i_b_cyc) begin
               state_next  = OWN_B;
               last_b_next = 1'b1;
            end
         end
         OWN_A:   if (!i_a_cyc || abort) state_next = IDLE;
         OWN_B:   if (!i_b_cyc || abort) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Bus routing. When idle the slave sees A's attributes, so the bus carries
   // defined values, but cyc and stb stay low.
   always_comb begin
      o_wb_cyc  = 1'b0;
      o_wb_stb  = 1'b0;
      o_wb_we   = i_a_we;
      o_wb_addr = i_a_addr;
      o_wb_data = i_a_data;
      o_wb_sel  = i_a_sel;
      o_a_ack   = 1'b0;
      o_a_err   = 1'b0;
      o_a_stall = i_a_cyc;
      o_b_ack   = 1'b0;
      o_b_err   = 1'b0;
      o_b_stall = i_b_cyc;
      case (state)
         OWN_A: begin
            o_wb_cyc  = i_a_cyc & ~abort;
            o_wb_stb  = i_a_stb & ~abort;
            o_a_stall = i_wb_stall;
            o_a_ack   = i_wb_ack;
            o_a_err   = i_wb_err | abort;
         end
         OWN_B: begin
            o_wb_cyc  = i_b_cyc & ~abort;
            o_wb_stb  = i_b_stb & ~abort;
            o_wb_we   = i_b_we;
            o_wb_addr = i_b_addr;
            o_wb_data = i_b_data;
            o_wb_sel  = i_b_sel;
            o_b_stall = i_wb_stall;
            o_b_ack   = i_wb_ack;
            o_b_err   = i_wb_err | abort;
         end
         default: ;
      endcase
   end

   // The watchdog counts cycles of an unanswered bus cycle. It saturates
   // instead of wrapping, so a stuck count cannot alias back below TIMEOUT.
   always_comb begin
      if (state == IDLE || i_wb_ack || i_wb_err)
         count_next = '0;
      else if (o_wb_cyc && count != COUNT_MAX)
         count_next = count + 10'd1;
      else
         count_next = count;
   end

   assign o_owner   = state;
   assign o_timeout = abort;

endmodule

// File: tb/tb_cpu_busarb.sv
// -----------------------------------------------------------------------------
// tb_cpu_busarb -- self-checking bench for cpu_busarb.
//
// Two instances share every input:
//   dut0: OPT_RR=0, TIMEOUT=4   (fixed priority, short watchdog)
//   dut1: OPT_RR=1, TIMEOUT=16  (alternating grants)
// Each cycle's expected status word is queued as stimulus is driven. The
// matching DUT word is queued at the falling edge, and the task compares
// the two queues at its end.
// Status word layout: owner[1:0] _ wb_cyc wb_stb _ a_ack a_stall a_err _
//                     b_ack b_stall b_err _ timeout
// -----------------------------------------------------------------------------
module tb_cpu_busarb;

   localparam int AW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
   logic [AW-1:0] a_addr, b_addr;
   logic [31:0] a_data, b_data;
   logic [3:0] a_sel, b_sel;
   logic wb_ack, wb_stall, wb_err;

   logic a_ack0, a_stall0, a_err0, b_ack0, b_stall0, b_err0;
   logic wb_cyc0, wb_stb0, wb_we0, timeout0;
   logic [AW-1:0] wb_addr0;
   logic [31:0] wb_data0;
   logic [3:0] wb_sel0;
   logic [1:0] owner0;

   logic a_ack1, a_stall1, a_err1, b_ack1, b_stall1, b_err1;
   logic wb_cyc1, wb_stb1, wb_we1, timeout1;
   logic [AW-1:0] wb_addr1;
   logic [31:0] wb_data1;
   logic [3:0] wb_sel1;
   logic [1:0] owner1;

   always #5 clk = ~clk;

   cpu_busarb #(.AW(AW), .TIMEOUT(4), .OPT_RR(0)) dut0 (
      .i_clk(clk), .i_rst(rst),
      .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr),
      .i_a_data(a_data), .i_a_sel(a_sel),
      .o_a_ack(a_ack0), .o_a_stall(a_stall0), .o_a_err(a_err0),
      .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr),
      .i_b_data(b_data), .i_b_sel(b_sel),
      .o_b_ack(b_ack0), .o_b_stall(b_stall0), .o_b_err(b_err0),
      .o_wb_cyc(wb_cyc0), .o_wb_stb(wb_stb0), .o_wb_we(wb_we0),
      .o_wb_addr(wb_addr0), .o_wb_data(wb_data0), .o_wb_sel(wb_sel0),
      .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err),
      .o_owner(owner0), .o_timeout(timeout0)
   );

   cpu_busarb #(.AW(AW), .TIMEOUT(16), .OPT_RR(1)) dut1 (
      .i_clk(clk), .i_rst(rst),
      .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr),
      .i_a_data(a_data), .i_a_sel(a_sel),
      .o_a_ack(a_ack1), .o_a_stall(a_stall1), .o_a_err(a_err1),
      .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr),
      .i_b_data(b_data), .i_b_sel(b_sel),
      .o_b_ack(b_ack1), .o_b_stall(b_stall1), .o_b_err(b_err1),
      .o_wb_cyc(wb_cyc1), .o_wb_stb(wb_stb1), .o_wb_we(wb_we1),
      .o_wb_addr(wb_addr1), .o_wb_data(wb_data1), .o_wb_sel(wb_sel1),
      .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err),
      .o_owner(owner1), .o_timeout(timeout1)
   );

   typedef struct {
      string       name;
      logic [63:0] val;
   } sb_t;

   sb_t         exp_q[$];
   logic [63:0] obs_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   function automatic logic [63:0] st0();
      return {53'd0, owner0, wb_cyc0, wb_stb0, a_ack0, a_stall0, a_err0,
              b_ack0, b_stall0, b_err0, timeout0};
   endfunction

   function automatic logic [63:0] st1();
      return {53'd0, owner1, wb_cyc1, wb_stb1, a_ack1, a_stall1, a_err1,
              b_ack1, b_stall1, b_err1, timeout1};
   endfunction

   function automatic logic [63:0] bus0();
      return {19'd0, wb_we0, wb_sel0, wb_addr0, wb_data0};
   endfunction

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic expect2(input string n, input logic [10:0] e0, input logic [10:0] e1);
      sb_t s;
      s.name = {n, "/dut0"}; s.val = {53'd0, e0}; exp_q.push_back(s);
      s.name = {n, "/dut1"}; s.val = {53'd0, e1}; exp_q.push_back(s);
   endtask

   task automatic sample2();
      @(negedge clk);
      obs_q.push_back(st0());
      obs_q.push_back(st1());
   endtask

   task automatic idle_inputs();
      a_cyc = 0; a_stb = 0; b_cyc = 0; b_stb = 0;
      wb_ack = 0; wb_err = 0; wb_stall = 0;
   endtask

   task automatic test_reset();
      sb_t s;
      logic [63:0] o;
      a_we = 0; a_addr = '0; a_data = '0; a_sel = '0;
      b_we = 0; b_addr = '0; b_data = '0; b_sel = '0;
      idle_inputs();
      rst = 1;
      @(posedge clk);
      expect2("reset_held", 11'b00_00_000_000_0, 11'b00_00_000_000_0);
      sample2();
      next(); rst = 0; wb_ack = 1;   // stray slave ack must not reach anyone
      expect2("reset_released", 11'b00_00_000_000_0, 11'b00_00_000_000_0);
      sample2();
      while (exp_q.size() != 0) begin
         s = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
         if (o !== s.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", s.name, o, s.val);
         end
      end
   endtask

   task automatic test_b_single();
      sb_t s;
      logic [63:0] o;
      next(); idle_inputs();
      b_cyc = 1; b_stb = 1; b_we = 1; b_addr = 8'h5A; b_data = 32'hDEADBEEF; b_sel = 4'hC;
      a_we = 0; a_addr = 8'h33; a_data = 32'h12345678; a_sel = 4'h3;
      expect2("b_req", 11'b00_00_000_010_0, 11'b00_00_000_010_0);
      s.name = "idle_bus_from_a"; s.val = {19'd0, 1'b0, 4'h3, 8'h33, 32'h12345678}; exp_q.push_back(s);
      sample2(); obs_q.push_back(bus0());
      next();
      expect2("b_grant", 11'b10_11_000_000_0, 11'b10_11_000_000_0);
      s.name = "b_bus_routed"; s.val = {19'd0, 1'b1, 4'hC, 8'h5A, 32'hDEADBEEF}; exp_q.push_back(s);
      sample2(); obs_q.push_back(bus0());
      next(); b_stb = 0; wb_ack = 1;
      expect2("b_ack", 11'b10_10_000_100_0, 11'b10_10_000_100_0);
      sample2();
      next(); wb_ack = 0; b_cyc = 0;
      expect2("b_drop", 11'b10_00_000_000_0, 11'b10_00_000_000_0);
      sample2();
      next();
      expect2("b_idle", 11'b00_00_000_000_0, 11'b00_00_000_000_0);
      sample2();
      while (exp_q.size() != 0) begin
         s = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
         if (o !== s.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", s.name, o, s.val);
         end
      end
   endtask

   task automatic test_contention();
      sb_t s;
      logic [63:0] o;
      // Two identical contentions: both arbiters grant A, then B.
      for (int rep = 0; rep < 2; rep++) begin
         next(); a_cyc = 1; a_stb = 1; b_cyc = 1; b_stb = 1;
         expect2($sformatf("c%0d_req", rep), 11'b00_00_010_010_0, 11'b00_00_010_010_0);
         sample2();
         next();
         expect2($sformatf("c%0d_grant_a", rep), 11'b01_11_000_010_0, 11'b01_11_000_010_0);
         sample2();
         next(); a_cyc = 0; a_stb = 0;
         expect2($sformatf("c%0d_a_drop", rep), 11'b01_00_000_010_0, 11'b01_00_000_010_0);
         sample2();
         next();
         expect2($sformatf("c%0d_idle_gap", rep), 11'b00_00_000_010_0, 11'b00_00_000_010_0);
         sample2();
         next();
         expect2($sformatf("c%0d_grant_b", rep), 11'b10_11_000_000_0, 11'b10_11_000_000_0);
         sample2();
         next(); b_cyc = 0; b_stb = 0;
         expect2($sformatf("c%0d_b_drop", rep), 11'b10_00_000_000_0, 11'b10_00_000_000_0);
         sample2();
         next();
         expect2($sformatf("c%0d_idle", rep), 11'b00_00_000_000_0, 11'b00_00_000_000_0);
         sample2();
      end
      // A alone, then contention: fixed priority picks A, round robin picks B.
      next(); a_cyc = 1; a_stb = 1;
      expect2("rr_a_req", 11'b00_00_010_000_0, 11'b00_00_010_000_0);
      sample2();
      next();
      expect2("rr_a_grant", 11'b01_11_000_000_0, 11'b01_11_000_000_0);
      sample2();
      next(); a_cyc = 0; a_stb = 0;
      expect2("rr_a_drop", 11'b01_00_000_000_0, 11'b01_00_000_000_0);
      sample2();
      next(); a_cyc = 1; a_stb = 1; b_cyc = 1; b_stb = 1;
      expect2("rr_both_req", 11'b00_00_010_010_0, 11'b00_00_010_010_0);
      sample2();
      next();
      expect2("rr_contended_grant", 11'b01_11_000_010_0, 11'b10_11_010_000_0);
      sample2();
      next(); a_cyc = 0; a_stb = 0; b_cyc = 0; b_stb = 0;
      expect2("rr_both_drop", 11'b01_00_000_000_0, 11'b10_00_000_000_0);
      sample2();
      next();
      expect2("rr_idle", 11'b00_00_000_000_0, 11'b00_00_000_000_0);
      sample2();
      while (exp_q.size() != 0) begin
         s = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
         if (o !== s.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", s.name, o, s.val);
         end
      end
   endtask

   task automatic test_timeout();
      sb_t s;
      logic [63:0] o;
      next(); b_cyc = 1; b_stb = 1;
      expect2("to_req", 11'b00_00_000_010_0, 11'b00_00_000_010_0);
      sample2();
      for (int i = 0; i < 4; i++) begin
         next();
         expect2($sformatf("to_wait%0d", i), 11'b10_11_000_000_0, 11'b10_11_000_000_0);
         sample2();
      end
      // dut0 (TIMEOUT=4) aborts on the 4th cycle after the grant; dut1 keeps going.
      next();
      expect2("to_abort", 11'b10_00_000_001_1, 11'b10_11_000_000_0);
      sample2();
      next();
      expect2("to_after_abort", 11'b00_00_000_010_0, 11'b10_11_000_000_0);
      sample2();
      next();
      expect2("to_rearbitrate", 11'b10_11_000_000_0, 11'b10_11_000_000_0);
      sample2();
      next(); b_cyc = 0; b_stb = 0;
      expect2("to_drop", 11'b10_00_000_000_0, 11'b10_00_000_000_0);
      sample2();
      next();
      expect2("to_idle", 11'b00_00_000_000_0, 11'b00_00_000_000_0);
      sample2();
      while (exp_q.size() != 0) begin
         s = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
         if (o !== s.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", s.name, o, s.val);
         end
      end
   endtask

   task automatic test_ack_beats_timeout();
      sb_t s;
      logic [63:0] o;
      next(); b_cyc = 1; b_stb = 1;
      expect2("aw_req", 11'b00_00_000_010_0, 11'b00_00_000_010_0);
      sample2();
      for (int i = 0; i < 4; i++) begin
         next();
         expect2($sformatf("aw_wait%0d", i), 11'b10_11_000_000_0, 11'b10_11_000_000_0);
         sample2();
      end
      next(); wb_ack = 1;
      expect2("aw_ack_wins", 11'b10_11_000_100_0, 11'b10_11_000_100_0);
      sample2();
      next(); wb_ack = 0; b_cyc = 0; b_stb = 0;
      expect2("aw_drop", 11'b10_00_000_000_0, 11'b10_00_000_000_0);
      sample2();
      next();
      expect2("aw_idle", 11'b00_00_000_000_0, 11'b00_00_000_000_0);
      sample2();
      while (exp_q.size() != 0) begin
         s = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
         if (o !== s.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", s.name, o, s.val);
         end
      end
   endtask

   task automatic test_reset_mid();
      sb_t s;
      logic [63:0] o;
      next(); a_cyc = 1; a_stb = 1;
      expect2("rm_req", 11'b00_00_010_000_0, 11'b00_00_010_000_0);
      sample2();
      next();
      expect2("rm_grant", 11'b01_11_000_000_0, 11'b01_11_000_000_0);
      sample2();
      next(); rst = 1;
      expect2("rm_rst_cycle", 11'b01_11_000_000_0, 11'b01_11_000_000_0);
      sample2();
      next(); rst = 0; wb_ack = 1;   // late ack from the killed cycle
      expect2("rm_after_rst", 11'b00_00_010_000_0, 11'b00_00_010_000_0);
      sample2();
      next(); wb_ack = 0; a_cyc = 0; a_stb = 0;
      expect2("rm_regrant_drop", 11'b01_00_000_000_0, 11'b01_00_000_000_0);
      sample2();
      next();
      expect2("rm_idle", 11'b00_00_000_000_0, 11'b00_00_000_000_0);
      sample2();
      while (exp_q.size() != 0) begin
         s = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
         if (o !== s.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", s.name, o, s.val);
         end
      end
   endtask

   task automatic test_back_to_back();
      sb_t s;
      logic [63:0] o;
      next(); b_cyc = 1; b_stb = 1;
      expect2("bb_b_req", 11'b00_00_000_010_0, 11'b00_00_000_010_0);
      sample2();
      next(); a_cyc = 1; a_stb = 1;
      expect2("bb_b_own_a_wait", 11'b10_11_010_000_0, 11'b10_11_010_000_0);
      sample2();
      next(); b_cyc = 0; b_stb = 0; wb_ack = 1;
      expect2("bb_ack_on_drop", 11'b10_00_010_100_0, 11'b10_00_010_100_0);
      sample2();
      next(); wb_ack = 0;
      expect2("bb_idle_gap", 11'b00_00_010_000_0, 11'b00_00_010_000_0);
      sample2();
      next();
      expect2("bb_grant_a", 11'b01_11_000_000_0, 11'b01_11_000_000_0);
      sample2();
      next(); a_cyc = 0; a_stb = 0;
      expect2("bb_a_drop", 11'b01_00_000_000_0, 11'b01_00_000_000_0);
      sample2();
      next();
      expect2("bb_idle", 11'b00_00_000_000_0, 11'b00_00_000_000_0);
      sample2();
      while (exp_q.size() != 0) begin
         s = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
         if (o !== s.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", s.name, o, s.val);
         end
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_b_single();
      test_contention();
      test_timeout();
      test_ack_beats_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_busarb.md
CPU_BUSARB -- requirements
Module: cpu_busarb

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width in words.
REQ-002 SHALL have parameter TIMEOUT, default 1023, meaning cycles without ack or err before a cycle is aborted; legal range 2..1023.
REQ-003 SHALL have parameter OPT_RR, default 0, meaning 0 = fixed priority to master A, 1 = alternate grants when A and B request together.
REQ-004 SHALL have ports: i_clk  in  1  clock; i_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have master A ports (data side): i_a_cyc, i_a_stb, i_a_we  in  1 each; i_a_addr  in  AW; i_a_data  in  32; i_a_sel  in  4; o_a_ack, o_a_stall, o_a_err  out  1 each.
REQ-006 SHALL have master B ports (instruction fetch): i_b_cyc, i_b_stb, i_b_we  in  1 each; i_b_addr  in  AW; i_b_data  in  32; i_b_sel  in  4; o_b_ack, o_b_stall, o_b_err  out  1 each.
REQ-007 SHALL have slave ports: o_wb_cyc, o_wb_stb, o_wb_we  out  1 each; o_wb_addr  out  AW; o_wb_data  out  32; o_wb_sel  out  4; i_wb_ack, i_wb_stall, i_wb_err  in  1 each; read data is not routed and reaches both masters directly.
REQ-008 SHALL have status ports: o_owner  out  2  (00 idle, 01 A, 10 B); o_timeout  out  1  one-cycle pulse on abort.

Function
REQ-009 SHALL hold a registered state IDLE, OWN_A or OWN_B, reflected on o_owner.
REQ-010 In IDLE: i_a_cyc high -> OWN_A next cycle; else i_b_cyc high -> OWN_B; else stay IDLE.
REQ-011 With OPT_RR=1 and both cyc high in IDLE, SHALL grant the master not granted most recently; the last-grant flag resets to B, so the first contended grant goes to A.
REQ-012 In OWN_X: owner cyc low -> IDLE next cycle; no direct OWN_A to OWN_B transition; the other master's request never preempts.
REQ-013 In IDLE: o_wb_cyc = o_wb_stb = 0, and o_a_stall/o_b_stall = 1 whenever that master's cyc is high; one-cycle grant latency.
REQ-014 In OWN_X: o_wb_cyc = i_X_cyc and o_wb_stb = i_X_stb; we, addr, data and sel are taken from X; o_X_stall = i_wb_stall, o_X_ack = i_wb_ack, o_X_err = i_wb_err, all combinational.
REQ-015 The non-owner SHALL see stall = 1 (when its cyc is high), ack = 0 and err = 0 at all times.
REQ-016 When idle, o_wb_we, addr, data and sel SHALL be driven from A, giving deterministic values.
REQ-017 SHALL keep a 10-bit timeout counter, zeroed in IDLE and on any cycle with i_wb_ack or i_wb_err, otherwise incremented each cycle while o_wb_cyc is high; no wrap.
REQ-018 When the counter equals TIMEOUT, SHALL take the following actions in that cycle:
- assert o_X_err to the owner;
- force o_wb_cyc = o_wb_stb = 0;
- pulse o_timeout;
- move to IDLE next cycle.
REQ-019 A slave ack or err arriving in the same cycle as the timeout SHALL win: it is passed to the owner, with no abort and no o_timeout pulse.
REQ-020 After an abort, a master still holding cyc high SHALL be re-arbitrated per REQ-010/011 like a new request.
REQ-021 If owner cyc drops while the slave raises ack in the same cycle, the ack SHALL still be routed to the owner and the state goes to IDLE.

Reset
REQ-022 On i_rst the following SHALL clear at the next clock edge, regardless of any bus cycle in progress:
- state IDLE;
- counter 0;
- last-grant flag B.
REQ-023 After reset: o_wb_cyc = 0, o_wb_stb = 0, o_owner = 00, o_timeout = 0, all acks/errs = 0; an outstanding slave ack after reset is discarded.

Verification
REQ-024 B cyc+stb alone at t0, slave stall 0, ack at t2 -> o_owner = 10 at t1, o_wb_stb at t1 with addr = B addr, o_b_ack at t2, IDLE after B drops cyc.
REQ-025 A and B cyc rise together, OPT_RR=0 -> A granted, B stalled throughout; B granted one cycle after A drops cyc; repeat -> A again.
REQ-026 Same stimulus with OPT_RR=1, repeated twice -> grants A, then B, then A first on the second contention.
REQ-027 TIMEOUT=4, B owns, slave never acks -> o_b_err and o_timeout high on the 4th cycle after grant, o_wb_cyc = 0 that cycle, o_owner = 00 next.
REQ-028 A owns mid-transfer, i_rst pulsed -> o_wb_cyc = 0 and o_owner = 00 next cycle; late i_wb_ack yields no o_a_ack.
REQ-029 B owns; A requests; slave ack on the same cycle B drops cyc -> o_b_ack = 1, o_a_ack = 0, A granted the following cycle.
